// File: rtl/epl_bch_lfsr_encoder_pkg.sv
// Shared constants and state encoding for the EPL sequential BCH encoder.
// The defaults reproduce the BCH(15,5,t=3) code shortened to 4 data bits.
package epl_bch_lfsr_encoder_pkg;

  localparam int BCH_N  = 15;
  localparam int BCH_K  = 5;
  localparam int BCH_DW = 4;
  localparam logic [10:0] BCH_GPOLY = 11'b10100110111;

  typedef enum logic [1:0] {
    EPL_ENC_IDLE  = 2'd0,
    EPL_ENC_SHIFT = 2'd1,
    EPL_ENC_DONE  = 2'd2
  } enc_state_t;

endpackage

// File: rtl/epl_bch_lfsr_step.sv
// One single-bit step of the BCH parity LFSR (division by GPOLY, MSB first).
module epl_bch_lfsr_step #(
  parameter int         P     = 10,
  parameter logic [P:0] GPOLY = 11'b10100110111
) (
  input  logic [P-1:0] par,
  input  logic         msg_bit,
  output logic [P-1:0] par_next
);

  logic fb_s;

  // Feedback is the incoming message bit xor the remainder MSB; fold GPOLY in when set
  always_comb begin
    fb_s = msg_bit ^ par[P-1];
    if (fb_s) begin
      par_next = {par[P-2:0], 1'b0} ^ GPOLY[P-1:0];
    end else begin
      par_next = {par[P-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/epl_bch_lfsr_encoder.sv
// Sequential systematic BCH encoder: BPC LFSR steps per cycle over K/BPC cycles,
// valid/ready handshake on both sides, codeword held under back-pressure.
module epl_bch_lfsr_encoder
  import epl_bch_lfsr_encoder_pkg::*;
#(
  parameter int           N     = BCH_N,
  parameter int           K     = BCH_K,
  parameter int           DW    = BCH_DW,
  parameter logic [N-K:0] GPOLY = BCH_GPOLY,
  parameter int           BPC   = 1
) (
  input  logic          pCLK_i,
  input  logic          nRST_i,
  input  logic          pWRITE_i,
  input  logic [DW-1:0] pDATA_i,
  output logic          pREADY_o,
  output logic [N-1:0]  pCODEWORD_o,
  output logic          pVALIDE_o,
  input  logic          pREADY_i,
  output logic          pBUSY_o
);

  localparam int P     = N - K;
  localparam int STEPS = K / BPC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS - 1);

  // Reject illegal parameter sets while elaborating
  if ((BPC < 1) || (BPC > K) || ((K % BPC) != 0) || (DW < 1) || (DW > K) ||
      (P < 2) || (GPOLY[P] != 1'b1)) begin : g_param_error
    $fatal(1, "epl_bch_lfsr_encoder: illegal parameter set");
  end

  enc_state_t      state_r;
  logic [K-1:0]    msg_r;
  logic [K-1:0]    pay_r;
  logic [P-1:0]    par_r;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    cw_r;
  logic            valid_r;
  logic            busy_r;
  logic [K-1:0]    pay_s;
  logic            ready_s;
  logic            accept_s;
  logic [P-1:0]    par_chain_s [0:BPC];

  // Zero-extend the user word into the K-bit payload; pad bits are constant zero
  always_comb begin
    pay_s = {K{1'b0}};
    pay_s[DW-1:0] = pDATA_i;
  end

  // Ready when idle, or when the held codeword is leaving this very cycle
  always_comb begin
    if (state_r == EPL_ENC_IDLE) begin
      ready_s = 1'b1;
    end else if (state_r == EPL_ENC_DONE) begin
      ready_s = pREADY_i;
    end else begin
      ready_s = 1'b0;
    end
    accept_s = pWRITE_i & ready_s;
  end

  assign par_chain_s[0] = par_r;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    epl_bch_lfsr_step #(
      .P     (P),
      .GPOLY (GPOLY)
    ) u_step (
      .par      (par_chain_s[i]),
      .msg_bit  (msg_r[K-1-i]),
      .par_next (par_chain_s[i+1])
    );
  end

  // Encoder FSM with its datapath registers and registered handshake outputs
  always_ff @(posedge pCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      state_r <= EPL_ENC_IDLE;
      msg_r   <= {K{1'b0}};
      pay_r   <= {K{1'b0}};
      par_r   <= {P{1'b0}};
      cnt_r   <= {CW{1'b0}};
      cw_r    <= {N{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        EPL_ENC_IDLE: begin
          if (accept_s) begin
            msg_r   <= pay_s;
            pay_r   <= pay_s;
            par_r   <= {P{1'b0}};
            cnt_r   <= CNT_LOAD;
            busy_r  <= 1'b1;
            state_r <= EPL_ENC_SHIFT;
          end else begin
            state_r <= EPL_ENC_IDLE;
          end
        end
        EPL_ENC_SHIFT: begin
          par_r <= par_chain_s[BPC];
          msg_r <= msg_r << BPC;
          if (cnt_r == {CW{1'b0}}) begin
            cw_r    <= {pay_r, par_chain_s[BPC]};
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= EPL_ENC_DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        EPL_ENC_DONE: begin
          if (pREADY_i) begin
            valid_r <= 1'b0;
            cw_r    <= {N{1'b0}};
            if (pWRITE_i) begin
              msg_r   <= pay_s;
              pay_r   <= pay_s;
              par_r   <= {P{1'b0}};
              cnt_r   <= CNT_LOAD;
              busy_r  <= 1'b1;
              state_r <= EPL_ENC_SHIFT;
            end else begin
              state_r <= EPL_ENC_IDLE;
            end
          end else begin
            state_r <= EPL_ENC_DONE;
          end
        end
        default: begin
          state_r <= EPL_ENC_IDLE;
          cw_r    <= {N{1'b0}};
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pREADY_o    = ready_s;
  assign pCODEWORD_o = cw_r;
  assign pVALIDE_o   = valid_r;
  assign pBUSY_o     = busy_r;

endmodule

// File: tb/tb_epl_bch_lfsr_encoder.sv
// Scoreboard bench for epl_bch_lfsr_encoder: a BPC=1 and a BPC=5 instance,
// exercised one at a time through a shared driver and output monitor.
module tb_epl_bch_lfsr_encoder;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [3:0]  data;
  logic        rdy_dir;
  logic        bp_rand;
  logic        rand_bp;
  logic        rdy_in;
  logic        sel;

  logic        ready1, v1, busy1;
  logic [14:0] cw1;
  logic        ready5, v5, busy5;
  logic [14:0] cw5;

  logic        ready_s, v_s, busy_s;
  logic [14:0] cw_s;

  int n_cmp;
  int n_err;
  int lat_g;
  logic [14:0] q[$];

  assign rdy_in  = rand_bp ? bp_rand : rdy_dir;
  assign ready_s = sel ? ready5 : ready1;
  assign v_s     = sel ? v5 : v1;
  assign busy_s  = sel ? busy5 : busy1;
  assign cw_s    = sel ? cw5 : cw1;

  epl_bch_lfsr_encoder dut1 (
    .pCLK_i      (clk),
    .nRST_i      (rst_n),
    .pWRITE_i    (wr & ~sel),
    .pDATA_i     (data),
    .pREADY_o    (ready1),
    .pCODEWORD_o (cw1),
    .pVALIDE_o   (v1),
    .pREADY_i    (rdy_in),
    .pBUSY_o     (busy1)
  );

  epl_bch_lfsr_encoder #(.BPC(5)) dut5 (
    .pCLK_i      (clk),
    .nRST_i      (rst_n),
    .pWRITE_i    (wr & sel),
    .pDATA_i     (data),
    .pREADY_o    (ready5),
    .pCODEWORD_o (cw5),
    .pVALIDE_o   (v5),
    .pREADY_i    (rdy_in),
    .pBUSY_o     (busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (bpc_sel=%0d t=%0t): observed 0x%0h expected 0x%0h", tag, sel, $time, obs, exp);
    end
  endtask

  // Reference: long division of payload*x^10 by the generator polynomial
  function automatic logic [14:0] ref_cw(input logic [3:0] d);
    logic [14:0] r;
    logic [14:0] g;
    g = 15'b000010100110111;
    r = {1'b0, d, 10'b0};
    for (int i = 14; i >= 10; i--) begin
      if (r[i]) r = r ^ (g << (i - 10));
    end
    return {1'b0, d, r[9:0]};
  endfunction

  task automatic send(input logic [3:0] d, input logic [14:0] exp, input bit push);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    wr = 1'b1;
    data = d;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready_s) begin
        ok = 1'b1;
        if (push) q.push_back(exp);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wr = 1'b0;
    data = 4'd0;
    if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat;
    int busy_n;
    lat = -1;
    busy_n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (v_s) begin
        lat = c - 1;
        break;
      end
      if (busy_s) busy_n++;
    end
    check_eq("latency", lat, exp_lat);
    check_eq("busy_cycles", busy_n, exp_lat);
  endtask

  task automatic run_word(input logic [3:0] d, input logic [14:0] exp);
    send(d, exp, 1'b1);
    wait_valid(lat_g);
    @(negedge clk);
    check_eq("valid_one_cycle", v_s, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, ready_s, 1'b1);
    check_eq({tag, "_valid"}, v_s, 1'b0);
    check_eq({tag, "_busy"}, busy_s, 1'b0);
    check_eq({tag, "_cw"}, cw_s, 15'h0000);
  endtask

  // Randomised downstream back-pressure, used only during the random phase
  initial begin
    bp_rand = 1'b1;
    forever begin
      @(posedge clk); #1;
      bp_rand = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: pops the scoreboard on each handshake, zero codeword otherwise
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (v_s) begin
          if (rdy_in) begin
            if (q.size() == 0) begin
              check_eq("unexpected_valid", {17'd0, cw_s}, 32'hFFFF_FFFF);
            end else begin
              e = q.pop_front();
              check_eq("codeword", cw_s, e);
            end
          end
        end else begin
          check_eq("cw_zero_when_invalid", cw_s, 15'h0000);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    wr = 1'b0;
    data = 4'd0;
    rdy_dir = 1'b1;
    rand_bp = 1'b0;
    sel = 1'b0;
    lat_g = 5;
    #12;
    check_reset_outputs("reset_bpc1");
    sel = 1'b1;
    #1;
    check_reset_outputs("reset_bpc5");
    sel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      lat_g = (s == 0) ? 5 : 1;
      @(posedge clk); #1;
      check_reset_outputs("idle");

      run_word(4'b1011, 15'h2C8F);
      run_word(4'b0001, 15'h0537);
      run_word(4'b1010, 15'h29B8);
      run_word(4'b0000, 15'h0000);

      // Back-pressure: hold the codeword, ignore writes, then back-to-back accept
      @(posedge clk); #1;
      rdy_dir = 1'b0;
      send(4'b1011, 15'h2C8F, 1'b1);
      wait_valid(lat_g);
      for (int i = 0; i < 7; i++) begin
        @(posedge clk); #1;
        wr = i[0];
        data = 4'b0000;
        @(negedge clk);
        check_eq("bp_hold_cw", cw_s, 15'h2C8F);
        check_eq("bp_hold_valid", v_s, 1'b1);
        check_eq("bp_ready_low", ready_s, 1'b0);
      end
      @(posedge clk); #1;
      rdy_dir = 1'b1;
      wr = 1'b1;
      data = 4'b0001;
      @(negedge clk);
      check_eq("b2b_ready", ready_s, 1'b1);
      q.push_back(15'h0537);
      @(posedge clk); #1;
      wr = 1'b0;
      data = 4'd0;
      wait_valid(lat_g);
      @(negedge clk);
      check_eq("b2b_valid_one_cycle", v_s, 1'b0);

      // Reset mid-flight: mid-SHIFT for BPC=1, mid-DONE for BPC=5
      if (s == 0) begin
        send(4'b1011, 15'h0000, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_reset_busy", busy_s, 1'b1);
      end else begin
        @(posedge clk); #1;
        rdy_dir = 1'b0;
        send(4'b1011, 15'h0000, 1'b0);
        wait_valid(lat_g);
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk); #1;
      rdy_dir = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check_eq("no_valid_after_reset", v_s, 1'b0);
      end
      run_word(4'b0001, 15'h0537);
      check_eq("directed_queue_empty", q.size(), 0);

      // Random words with random back-pressure against the division model
      @(posedge clk); #1;
      rand_bp = 1'b1;
      for (int w = 0; w < 1000; w++) begin
        logic [3:0] d;
        d = 4'($urandom_range(0, 15));
        send(d, ref_cw(d), 1'b1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      for (int c = 0; c < 500 && q.size() != 0; c++) @(negedge clk);
      check_eq("random_drain", q.size(), 0);
      @(posedge clk); #1;
      rand_bp = 1'b0;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
